// File: rtl/lector_contador_pkg.sv
// lector_contador_pkg
// Definitions shared by the readout FSM, its wait timer and the bench:
//   estado_t     - 2-bit state encoding of the readout FSM
//   TIMEOUT_DEF  - default number of cycles to wait for a counter response
//   suma4        - zero-extended sum of the four captured counter values
package lector_contador_pkg;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        PIDE   = 2'd1,
        RECIBE = 2'd2,
        FIN    = 2'd3
    } estado_t;

    localparam int TIMEOUT_DEF = 8;
    localparam int TMR_W       = 4;
    localparam int CNT_W       = 5;
    localparam int TOT_W       = 7;

    // Four 5-bit values never exceed 124, so 7 bits cannot overflow.
    function automatic logic [TOT_W-1:0] suma4(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b,
                                               input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

endpackage

// File: rtl/lector_contador_temporizador_espera.sv
// temporizador_espera
// 4-bit down-counter that measures how long the readout FSM has waited for a
// counter response.
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   clr     in   reload the count (issued in the request cycle)
//   en      in   count one waiting cycle
//   expira  out  high during the TIMEOUT-th enabled cycle after a reload
module temporizador_espera
    import lector_contador_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expira
);

    // Loading TIMEOUT-1 makes terminal count coincide with the last of
    // exactly TIMEOUT waiting cycles.
    localparam logic [TMR_W-1:0] CARGA = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (clr) begin
            cuenta_d = CARGA;
        end else if (en && (cuenta_q != '0)) begin
            cuenta_d = cuenta_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign expira = en && (cuenta_q == '0);

endmodule

// File: rtl/lector_contador.sv
// lector_contador
// Reads the four counters F0..F3 of the counter block one index at a time and
// keeps the captured values plus their sum.
//   clk, reset          rising-edge clock, synchronous active-high reset
//   IDLE                counter block idle; readout allowed only while high
//   start               one-cycle request for a full readout
//   valid_contador      counter response valid
//   contador_out[4:0]   counter value for the requested index
//   req, idx[1:0]       read request and index being requested
//   cnt0..cnt3[4:0]     captured values
//   total[6:0]          sum of cnt0..cnt3, updated when a readout finishes
//   busy, done          readout in progress / one-cycle finish pulse
//   err_timeout         some index timed out during the last readout
//   err_abort           IDLE fell during the last readout
//
// state  | meaning
// ESPERA | idle, waiting for start with IDLE high
// PIDE   | request cycle: req high for one cycle, wait timer reloaded
// RECIBE | waiting for valid_contador or timer expiry for index idx
// FIN    | readout finished: done pulse, total valid
//
// Every output is a flop whose next value is decoded from the next state, so
// req/busy/done line up with the state they describe without any
// input-to-output combinational path.
module lector_contador
    import lector_contador_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDLE,
    input  logic             start,
    input  logic             valid_contador,
    input  logic [CNT_W-1:0] contador_out,
    output logic             req,
    output logic [1:0]       idx,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [TOT_W-1:0] total,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_abort
);

    estado_t                     state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [TOT_W-1:0]            total_q, total_d;
    logic                        req_q, req_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_t_q, err_t_d;
    logic                        err_a_q, err_a_d;

    logic expira;
    logic captura;

    temporizador_espera #(
        .TIMEOUT (TIMEOUT)
    ) u_temporizador_espera (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q == PIDE),
        .en     (state_q == RECIBE),
        .expira (expira)
    );

    // A response during PIDE is deliberately not sampled.
    assign captura = (state_q == RECIBE) && valid_contador;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ESPERA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ESPERA: if (start && IDLE) state_d = PIDE;
            PIDE:   state_d = IDLE ? RECIBE : FIN;
            RECIBE: begin
                if (!IDLE) begin
                    state_d = FIN;
                end else if (captura || expira) begin
                    state_d = (idx_q == 2'd3) ? FIN : PIDE;
                end
            end
            FIN:    state_d = ESPERA;
            default: state_d = ESPERA;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        err_t_d = err_t_q;
        err_a_d = err_a_q;
        req_d   = (state_d == PIDE);
        busy_d  = (state_d != ESPERA);
        done_d  = (state_d == FIN);

        case (state_q)
            ESPERA: begin
                if (state_d == PIDE) begin
                    idx_d   = 2'd0;
                    err_t_d = 1'b0;
                    err_a_d = 1'b0;
                end
            end
            PIDE: begin
                if (!IDLE) err_a_d = 1'b1;
            end
            RECIBE: begin
                // A capture coinciding with IDLE falling is kept; a bare
                // expiry coinciding with it is treated as the abort only.
                if (captura) begin
                    cnt_d[idx_q] = contador_out;
                end else if (expira && IDLE) begin
                    cnt_d[idx_q] = '0;
                    err_t_d      = 1'b1;
                end
                if (!IDLE) begin
                    err_a_d = 1'b1;
                end else if ((captura || expira) && (idx_q != 2'd3)) begin
                    idx_d = idx_q + 2'd1;
                end
            end
            FIN: begin
                idx_d = 2'd0;
            end
            default: ;
        endcase

        // Sum of the values being written on the same edge, so total is
        // already valid while done is high.
        if (state_d == FIN) begin
            total_d = suma4(cnt_d[0], cnt_d[1], cnt_d[2], cnt_d[3]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            total_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_t_q <= 1'b0;
            err_a_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_t_q <= err_t_d;
            err_a_q <= err_a_d;
        end
    end

    assign req         = req_q;
    assign idx         = idx_q;
    assign cnt0        = cnt_q[0];
    assign cnt1        = cnt_q[1];
    assign cnt2        = cnt_q[2];
    assign cnt3        = cnt_q[3];
    assign total       = total_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_t_q;
    assign err_abort   = err_a_q;

endmodule

// File: tb/tb_lector_contador.sv
// tb_lector_contador
// Scenario bench for lector_contador: a responder models the counter block,
// each readout pushes its expected result onto a scoreboard queue and the
// result is popped and compared when done pulses.
module tb_lector_contador;
    import lector_contador_pkg::*;

    logic       clk = 1'b0;
    logic       reset, IDLE, start, valid_contador;
    logic [4:0] contador_out;
    logic       req, busy, done, err_timeout, err_abort;
    logic [1:0] idx;
    logic [4:0] cnt0, cnt1, cnt2, cnt3;
    logic [6:0] total;

    lector_contador #(.TIMEOUT(TIMEOUT_DEF)) dut (
        .clk            (clk),
        .reset          (reset),
        .IDLE           (IDLE),
        .start          (start),
        .valid_contador (valid_contador),
        .contador_out   (contador_out),
        .req            (req),
        .idx            (idx),
        .cnt0           (cnt0),
        .cnt1           (cnt1),
        .cnt2           (cnt2),
        .cnt3           (cnt3),
        .total          (total),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout),
        .err_abort      (err_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] c0, c1, c2, c3;
        logic [6:0] total;
        logic       et, ea;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] model[4];
    logic [4:0] resp_vals[4];
    int         resp_delay = 2;
    logic [3:0] resp_skip  = 4'b0000;
    int         req_cnt  = 0;
    int         done_cnt = 0;
    int         wait_idx2 = 0;

    always @(negedge clk) begin
        if (req === 1'b1) req_cnt++;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && req === 1'b0 && idx === 2'd2) wait_idx2++;
    end

    // Counter block model: answers resp_delay cycles after the request cycle.
    always begin : responder
        logic [1:0] k;
        @(negedge clk);
        if (req === 1'b1 && !resp_skip[idx]) begin
            k = idx;
            repeat (resp_delay) @(posedge clk);
            #1 valid_contador = 1'b1;
            contador_out = resp_vals[k];
            @(posedge clk);
            #1 valid_contador = 1'b0;
            contador_out = 5'd0;
        end
    end

    function automatic exp_t mk(input logic et, input logic ea);
        exp_t e;
        e.c0 = model[0];
        e.c1 = model[1];
        e.c2 = model[2];
        e.c3 = model[3];
        e.total = {2'b00, model[0]} + {2'b00, model[1]} + {2'b00, model[2]} + {2'b00, model[3]};
        e.et = et;
        e.ea = ea;
        return e;
    endfunction

    function automatic exp_t snap();
        exp_t s;
        s.c0 = cnt0;
        s.c1 = cnt1;
        s.c2 = cnt2;
        s.c3 = cnt3;
        s.total = total;
        s.et = err_timeout;
        s.ea = err_abort;
        return s;
    endfunction

    task automatic set_resp(input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [4:0] d, input int dly);
        resp_vals[0] = a; resp_vals[1] = b; resp_vals[2] = c; resp_vals[3] = d;
        resp_delay = dly;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cond_idx(input logic [1:0] want, input bit need_valid, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && req === 1'b0 && idx === want &&
                (!need_valid || valid_contador === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (snap() !== exp_t'(0)) begin
            n_bad++; $display("FAIL reset_values: got %h expected %h", snap(), exp_t'(0));
        end
        n_cmp++;
        if ({req, idx, busy, done} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got req/idx/busy/done %b expected 00000", {req, idx, busy, done});
        end
    endtask

    task automatic test_normal();
        bit ok;
        exp_t e;
        set_resp(5'd3, 5'd7, 5'd0, 5'd31, 2);
        resp_skip = 4'b0000;
        model[0] = 5'd3; model[1] = 5'd7; model[2] = 5'd0; model[3] = 5'd31;
        sb.push_back(mk(1'b0, 1'b0));
        req_cnt = 0;
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL normal_done: got no done expected done within 200 cycles");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (snap() !== e) begin
                n_bad++; $display("FAIL normal_result: got %h expected %h", snap(), e);
            end
            n_cmp++;
            if (req_cnt !== 4) begin
                n_bad++; $display("FAIL normal_reqs: got %0d expected 4", req_cnt);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL normal_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        exp_t e;
        set_resp(5'd5, 5'd9, 5'd22, 5'd12, 2);
        resp_skip = 4'b0100;
        model[0] = 5'd5; model[1] = 5'd9; model[2] = 5'd0; model[3] = 5'd12;
        sb.push_back(mk(1'b1, 1'b0));
        wait_idx2 = 0;
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL timeout_done: got no done expected done within 200 cycles");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (snap() !== e) begin
                n_bad++; $display("FAIL timeout_result: got %h expected %h", snap(), e);
            end
            n_cmp++;
            if (wait_idx2 !== TIMEOUT_DEF) begin
                n_bad++; $display("FAIL timeout_cycles: got %0d expected %0d", wait_idx2, TIMEOUT_DEF);
            end
        end
        resp_skip = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok;
        exp_t e;
        set_resp(5'd1, 5'd2, 5'd3, 5'd4, 5);
        model[0] = 5'd1;
        sb.push_back(mk(1'b0, 1'b1));
        pulse_start();
        wait_cond_idx(2'd1, 1'b0, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL abort_reach: got no wait on idx1 expected one");
        end else begin
            IDLE = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b1) begin
                n_bad++; $display("FAIL abort_done: got %b expected 1", done);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (snap() !== e) begin
                    n_bad++; $display("FAIL abort_result: got %h expected %h", snap(), e);
                end
            end
        end
        IDLE = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_capture_abort();
        bit ok;
        exp_t e;
        set_resp(5'd17, 5'd2, 5'd3, 5'd4, 2);
        model[0] = 5'd17;
        sb.push_back(mk(1'b0, 1'b1));
        pulse_start();
        wait_cond_idx(2'd0, 1'b1, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL capabort_reach: got no valid on idx0 expected one");
        end else begin
            IDLE = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b1) begin
                n_bad++; $display("FAIL capabort_done: got %b expected 1", done);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (snap() !== e) begin
                    n_bad++; $display("FAIL capabort_result: got %h expected %h", snap(), e);
                end
            end
        end
        IDLE = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        bit ok;
        exp_t e;
        IDLE = 1'b0;
        req_cnt = 0;
        pulse_start();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (req_cnt !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL start_idle_low: got reqs=%0d busy=%b expected 0 0", req_cnt, busy);
        end
        IDLE = 1'b1;
        set_resp(5'd10, 5'd11, 5'd12, 5'd13, 2);
        model[0] = 5'd10; model[1] = 5'd11; model[2] = 5'd12; model[3] = 5'd13;
        sb.push_back(mk(1'b0, 1'b0));
        req_cnt = 0;
        done_cnt = 0;
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL busy_start_done: got no done expected done within 200 cycles");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (snap() !== e) begin
                n_bad++; $display("FAIL busy_start_result: got %h expected %h", snap(), e);
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (req_cnt !== 4 || done_cnt !== 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_start_once: got reqs=%0d dones=%0d busy=%b expected 4 1 0",
                              req_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_valid_in_pide();
        bit ok;
        exp_t e;
        set_resp(5'd9, 5'd9, 5'd9, 5'd9, 0);
        model[0] = 5'd0; model[1] = 5'd0; model[2] = 5'd0; model[3] = 5'd0;
        sb.push_back(mk(1'b1, 1'b0));
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL pide_valid_done: got no done expected done within 200 cycles");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (snap() !== e) begin
                n_bad++; $display("FAIL pide_valid_result: got %h expected %h", snap(), e);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        exp_t e;
        set_resp(5'd6, 5'd6, 5'd6, 5'd6, 3);
        pulse_start();
        wait_cond_idx(2'd2, 1'b0, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL rstmid_reach: got no wait on idx2 expected one");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        n_cmp++;
        if (snap() !== exp_t'(0) || {req, idx, busy, done} !== 5'b0) begin
            n_bad++; $display("FAIL rstmid_zero: got %h ctrl %b expected 0 00000", snap(), {req, idx, busy, done});
        end
        model[0] = 5'd0; model[1] = 5'd0; model[2] = 5'd0; model[3] = 5'd0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (done_cnt !== 0) begin
            n_bad++; $display("FAIL rstmid_nodone: got %0d done pulses expected 0", done_cnt);
        end
        set_resp(5'd1, 5'd2, 5'd3, 5'd4, 2);
        model[0] = 5'd1; model[1] = 5'd2; model[2] = 5'd3; model[3] = 5'd4;
        sb.push_back(mk(1'b0, 1'b0));
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL rstmid_after_done: got no done expected done within 200 cycles");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (snap() !== e) begin
                n_bad++; $display("FAIL rstmid_after_result: got %h expected %h", snap(), e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        IDLE = 1'b1;
        start = 1'b0;
        valid_contador = 1'b0;
        contador_out = 5'd0;
        set_resp(5'd0, 5'd0, 5'd0, 5'd0, 2);
        test_reset();
        test_normal();
        test_timeout();
        test_abort();
        test_capture_abort();
        test_start_ignored();
        test_valid_in_pide();
        test_reset_mid();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lector_contador.md
LECTOR_CONTADOR -- requirements
Module: lector_contador

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; clock port is clk and reset port is reset.
REQ-002 SHALL have parameter TIMEOUT, default 8, meaning the number of cycles to wait for valid_contador per index (range 2..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 IDLE  input  1  counter block idle; readout is permitted only while this is high.
REQ-006 start  input  1  single-cycle pulse requesting a full readout of all four counters.
REQ-007 valid_contador  input  1  counter response valid.
REQ-008 contador_out  input  5  counter value for the requested index.
REQ-009 req  output  1  read request to the counter block.
REQ-010 idx  output  2  index being requested (0..3, maps to F0..F3).
REQ-011 cnt0, cnt1, cnt2, cnt3  output  5 each  captured counter values.
REQ-012 total  output  7  sum of cnt0..cnt3.
REQ-013 busy  output  1  readout in progress.
REQ-014 done  output  1  one-cycle pulse when a readout finishes, including a timed-out finish.
REQ-015 err_timeout  output  1  sticky flag: at least one index timed out during the last readout.
REQ-016 err_abort  output  1  sticky flag: IDLE fell during the last readout.

Function
REQ-017 SHALL implement the FSM states ESPERA, PIDE, RECIBE and FIN.
REQ-018 ESPERA -> PIDE when start=1 and IDLE=1 in the same cycle; start is ignored when IDLE=0 and when not in ESPERA.
REQ-019 On entering PIDE from ESPERA: idx=0; err_timeout and err_abort cleared; cnt0..cnt3 and total retain old values until overwritten.
REQ-020 PIDE SHALL drive req=1 for exactly one cycle, then go to RECIBE and clear the wait counter.
REQ-021 RECIBE holds req=0 and waits for valid_contador=1, then captures contador_out into cnt[idx] on that edge.
REQ-022 If valid_contador arrives in the PIDE cycle itself, it SHALL be ignored; only RECIBE samples it.
REQ-023 If TIMEOUT cycles elapse in RECIBE without valid_contador: cnt[idx] <= 0; err_timeout <= 1; advance as if captured.
REQ-024 Advance after a capture or timeout: if idx<3, idx <= idx+1 and go to PIDE; if idx=3, go to FIN.
REQ-025 FIN lasts one cycle: done=1, total updated, then return to ESPERA; idx returns to 0.
REQ-026 total SHALL be the zero-extended 7-bit sum of the four 5-bit values (max 124, no overflow), registered and updated only in FIN.
REQ-027 IDLE=0 in PIDE or RECIBE: err_abort <= 1; go to FIN next cycle; indices not yet read keep their prior cnt values; req=0 in the abort cycle.
REQ-028 Simultaneous valid_contador and IDLE falling in RECIBE: capture first, then abort (the value is kept and err_abort is set).
REQ-029 busy=1 in PIDE, RECIBE and FIN; 0 in ESPERA.
REQ-030 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-031 reset=1 at a clock edge: state=ESPERA, req=0, idx=0, cnt0..cnt3=0, total=0, busy=0, done=0, err_timeout=0, err_abort=0.
REQ-032 reset SHALL take priority over every other input, including mid-readout; an in-flight readout is discarded and no done pulse is produced.

Structure
REQ-033 FSM state encodings (2-bit) and the default TIMEOUT SHALL live in a shared defines file, also used by contador and its testbench.
REQ-034 The wait counter SHALL be the sub-module temporizador_espera (inputs clk, reset, clr, en; output expira), 4 bits wide.
REQ-035 The design SHALL be synthesizable by the team's Yosys flow into a lector_contador_s netlist that is equivalent cycle for cycle.

Verification
REQ-036 IDLE=1, start pulse, counter answers 2 cycles after each req with 3,7,0,31 -> cnt0..cnt3 = 3,7,0,31; total=41; done pulse 1 cycle; err flags 0.
REQ-037 Counter never answers idx=2, TIMEOUT=8 -> exactly 8 wait cycles on idx 2, then cnt2=0, err_timeout=1, done still pulses, total = cnt0+cnt1+cnt3.
REQ-038 IDLE falls while waiting on idx=1 -> err_abort=1, done 1 cycle later, cnt2 and cnt3 unchanged from the previous readout.
REQ-039 start with IDLE=0, and start while busy -> no req issued and the running readout is unaffected.
REQ-040 reset asserted in RECIBE for idx=2 -> next cycle all outputs are zero and in ESPERA; a later start works normally.
REQ-041 All scenarios SHALL be run on the behavioural and synthesized models in parallel, with outputs compared every cycle; there must be zero mismatches.
